mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Sequencer for one fully-connected MLP layer. Walks every (output j, input i) pair in
//  row-major order and emits per-beat stage-1 controls into the buffer/MAC pipeline:
//  neuron/weight read addresses, reset_mult_acc, write_neuron, out_neuron_addr and done.
//  Drives the pipeline-wide run enable, drains the pipeline and pulses layer_done.
// PARAMETERS
//  ADDR_W    12  neuron memory address width (matches out_neuron_addr)
//  WADDR_W   16  weight memory address width
//  PIPE_LAT  4   cycles from a stage-1 beat to its write at the pipeline tail (drain length)
// PORTS
//  clk               in   1        single clock, all logic on posedge
//  reset             in   1        synchronous, active-high
//  start             in   1        layer start request; sampled only in IDLE
//  num_inputs        in   ADDR_W   N_in, inputs per output neuron
//  num_outputs       in   ADDR_W   N_out, output neurons
//  in_base_addr      in   ADDR_W   neuron-memory base of the input vector
//  out_base_addr     in   ADDR_W   neuron-memory base of the output vector
//  weight_base_addr  in   WADDR_W  weight-memory base; row j at base + j*N_in
//  run               out  1        pipeline enable to all buffer stages; 0 clears them
//  busy              out  1        high from LOAD through DONE
//  beat_valid_1      out  1        stage-1 beat issued this cycle
//  neuron_rd_addr    out  ADDR_W   in_base + i
//  weight_rd_addr    out  WADDR_W  weight_base + j*N_in + i
//  reset_mult_acc_1  out  1        first beat of a neuron (i==0)
//  write_neuron_1    out  1        last beat of a neuron (i==N_in-1)
//  out_neuron_addr_1 out  ADDR_W   out_base + j, valid on every beat
//  done_1            out  1        last beat of the layer (j==N_out-1, i==N_in-1)
//  layer_done        out  1        one-cycle pulse after the pipeline has drained
// BEHAVIOUR
//  - All outputs registered. Reset (any state, mid-layer included): state=IDLE, every output 0.
//  - FSM: IDLE -start-> LOAD -> MAC -> FLUSH -> DONE -> IDLE.
//    LOAD: latch all config inputs; later config changes are ignored until the next start.
//    Empty layer (N_in==0 or N_out==0): LOAD -> DONE directly; no beats, run stays 0.
//  - MAC: one beat per cycle, no stalls. The first beat is visible the cycle after LOAD,
//    so beat 0 appears 2 clocks after start is sampled. Total beats = N_in*N_out.
//    i increments each beat; at N_in-1 it wraps to 0 and j increments.
//    weight_rd_addr increments by 1 every beat; the product j*N_in is never computed.
//  - N_in==1: reset_mult_acc_1 and write_neuron_1 are both high on the same beat.
//  - Leaving MAC drops beat_valid_1 and all per-beat flags to 0. Addresses hold their last value.
//  - FLUSH: exactly PIPE_LAT cycles, run held 1. DONE: one cycle, layer_done=1, run=1.
//    On return to IDLE, run=0 and busy=0.
//  - run=1 from the first MAC beat through DONE.
//  - start while busy: ignored, not queued.
//  - Address arithmetic is modulo 2^ADDR_W and 2^WADDR_W. Wrap is silent, not an error.
// STRUCTURE
//  - Package mlp_pkg: seq_state_t enum (IDLE, LOAD, MAC, FLUSH, DONE), ADDR_W/WADDR_W
//    defaults, PIPE_LAT constant shared with the buffer stages.
//  - Sub-module mlp_loop_counter: nested i/j counter with clear/enable.
//    Outputs i, j, first_i, last_i, last_all.
//  - Top: FSM, address registers, flush counter.
// TESTING
//  1. N_in=3, N_out=2, bases 0x010/0x100/0x0200, start 1 cycle -> 6 beats.
//     neuron_rd 10,11,12,10,11,12; weight_rd 200..205.
//     reset on beats 0 and 3; write on beats 2 and 5 with out addr 100 then 101.
//     done_1 on beat 5; layer_done 4 cycles after beat 5's flush starts.
//  2. N_in=1, N_out=1 -> one beat with reset, write and done_1 all high.
//     layer_done exactly PIPE_LAT+1 cycles later.
//  3. N_in=0, N_out=5 -> no beat_valid_1 and run never 1.
//     layer_done pulses 2 cycles after start.
//  4. reset asserted on beat 4 of test 1 -> next cycle all outputs 0, IDLE.
//     A fresh start replays the full sequence from beat 0.
//  5. start re-pulsed mid-MAC, with num_inputs changed to 7 -> ignored.
//     Beat count and addresses unchanged from the latched config.
//  6. in_base=0xFFE, N_in=4, weight_base=0xFFFE -> neuron_rd FFE,FFF,000,001.
//     weight_rd FFFE,FFFF,0000,0001.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer datapath.
//   - Default address widths for neuron and weight memories.
//   - PIPE_LAT: latency from a stage-1 beat to its write at the pipeline
//     tail; the sequencer drains this many cycles before reporting done.
//   - Sequencer state encoding (constants plus an enum view of them).
package mlp_pkg;

   localparam int ADDR_W_DEFAULT  = 12;
   localparam int WADDR_W_DEFAULT = 16;
   localparam int PIPE_LAT        = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      LOAD  = S_LOAD,
      MAC   = S_MAC,
      FLUSH = S_FLUSH,
      DONE  = S_DONE
   } seq_state_t;

endpackage

// File: rtl/mlp_loop_counter.sv
// Nested row-major loop counter: i runs 0..n_in-1, then wraps and j steps.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             force i=j=0
//   enable            advance one position
//   n_in, n_out       loop bounds (n_in must be nonzero while enabled)
//   i, j              current indices
//   first_i           i==0
//   last_i            i==n_in-1
//   last_all          last_i and j==n_out-1
module mlp_loop_counter #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] n_in,
   input  logic [W-1:0] n_out,
   output logic [W-1:0] i,
   output logic [W-1:0] j,
   output logic         first_i,
   output logic         last_i,
   output logic         last_all
);

   always_comb begin
      first_i  = (i == '0);
      last_i   = (i == n_in - W'(1));
      last_all = last_i && (j == n_out - W'(1));
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         i <= '0;
         j <= '0;
      end else if (enable) begin
         if (last_i) begin
            i <= '0;
            j <= j + W'(1);
         end else begin
            i <= i + W'(1);
         end
      end
   end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequencer for one fully-connected MLP layer. Issues one stage-1 beat per
// (output j, input i) pair in row-major order, then drains the pipeline for
// PIPE_LAT cycles and pulses layer_done.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start                            layer request, honoured only when idle
//   num_inputs / num_outputs         N_in / N_out
//   in_base_addr / out_base_addr     neuron-memory bases
//   weight_base_addr                 weight-memory base (row j at base+j*N_in)
//   run                              pipeline enable, 0 clears the stages
//   busy                             high LOAD through DONE
//   beat_valid_1                     a beat is issued this cycle
//   neuron_rd_addr, weight_rd_addr   read addresses of the beat
//   reset_mult_acc_1, write_neuron_1 first / last beat of a neuron
//   out_neuron_addr_1                out_base + j
//   done_1                           last beat of the layer
//   layer_done                       one-cycle pulse after drain
//   state_dbg                        current FSM state (debug)
//
// Handshake: start is a level sampled only in IDLE; it is neither acknowledged
// nor queued. Beats are issued unconditionally (no back-pressure), one per
// cycle while beat_valid_1 is high.
module mlp_layer_sequencer
   import mlp_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int WADDR_W = WADDR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  num_inputs,
   input  logic [ADDR_W-1:0]  num_outputs,
   input  logic [ADDR_W-1:0]  in_base_addr,
   input  logic [ADDR_W-1:0]  out_base_addr,
   input  logic [WADDR_W-1:0] weight_base_addr,
   output logic               run,
   output logic               busy,
   output logic               beat_valid_1,
   output logic [ADDR_W-1:0]  neuron_rd_addr,
   output logic [WADDR_W-1:0] weight_rd_addr,
   output logic               reset_mult_acc_1,
   output logic               write_neuron_1,
   output logic [ADDR_W-1:0]  out_neuron_addr_1,
   output logic               done_1,
   output logic               layer_done,
   output logic [2:0]         state_dbg
);

   localparam int FLUSH_W = $clog2(PIPE_LAT) + 1;

   logic [2:0]         state;
   logic [ADDR_W-1:0]  cfg_n_in;
   logic [ADDR_W-1:0]  cfg_n_out;
   logic [ADDR_W-1:0]  cfg_in_base;
   logic [ADDR_W-1:0]  cfg_out_base;
   logic [WADDR_W-1:0] w_ptr;
   logic [FLUSH_W-1:0] flush_cnt;

   logic [ADDR_W-1:0]  cnt_i;
   logic [ADDR_W-1:0]  cnt_j;
   logic               first_i;
   logic               last_i;
   logic               last_all;

   logic               empty_layer;
   logic               issue_beat;

   assign state_dbg   = state;
   assign empty_layer = (cfg_n_in == '0) || (cfg_n_out == '0);

   // The beat just registered in MAC carries done_1 when it was the last one,
   // so a registered done_1 means "nothing more to issue".
   assign issue_beat = ((state == S_LOAD) && !empty_layer) ||
                       ((state == S_MAC) && !done_1);

   mlp_loop_counter #(.W(ADDR_W)) u_loop (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == S_IDLE),
      .enable   (issue_beat),
      .n_in     (cfg_n_in),
      .n_out    (cfg_n_out),
      .i        (cnt_i),
      .j        (cnt_j),
      .first_i  (first_i),
      .last_i   (last_i),
      .last_all (last_all)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         cfg_n_in          <= '0;
         cfg_n_out         <= '0;
         cfg_in_base       <= '0;
         cfg_out_base      <= '0;
         w_ptr             <= '0;
         flush_cnt         <= '0;
         run               <= 1'b0;
         busy              <= 1'b0;
         beat_valid_1      <= 1'b0;
         neuron_rd_addr    <= '0;
         weight_rd_addr    <= '0;
         reset_mult_acc_1  <= 1'b0;
         write_neuron_1    <= 1'b0;
         out_neuron_addr_1 <= '0;
         done_1            <= 1'b0;
         layer_done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cfg_n_in     <= num_inputs;
                  cfg_n_out    <= num_outputs;
                  cfg_in_base  <= in_base_addr;
                  cfg_out_base <= out_base_addr;
                  w_ptr        <= weight_base_addr;
                  busy         <= 1'b1;
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (empty_layer) begin
                  layer_done <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  run   <= 1'b1;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               if (done_1) begin
                  // Flags drop; addresses keep their last beat's value.
                  beat_valid_1     <= 1'b0;
                  reset_mult_acc_1 <= 1'b0;
                  write_neuron_1   <= 1'b0;
                  done_1           <= 1'b0;
                  flush_cnt        <= '0;
                  state            <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == FLUSH_W'(PIPE_LAT - 1)) begin
                  layer_done <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_W'(1);
               end
            end
            S_DONE: begin
               layer_done <= 1'b0;
               run        <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // The weight pointer walks linearly across rows, so j*N_in is never formed.
         if (issue_beat) begin
            beat_valid_1      <= 1'b1;
            neuron_rd_addr    <= cfg_in_base + cnt_i;
            weight_rd_addr    <= w_ptr;
            w_ptr             <= w_ptr + WADDR_W'(1);
            reset_mult_acc_1  <= first_i;
            write_neuron_1    <= last_i;
            out_neuron_addr_1 <= cfg_out_base + cnt_j;
            done_1            <= last_all;
         end
      end
   end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer. A reference model lists every
// expected beat from nested loops with plain multiplication, and the expected
// cycle of every control event from the beat count.
module tb_mlp_layer_sequencer;
   import mlp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] num_inputs;
   logic [11:0] num_outputs;
   logic [11:0] in_base_addr;
   logic [11:0] out_base_addr;
   logic [15:0] weight_base_addr;
   logic        run;
   logic        busy;
   logic        beat_valid_1;
   logic [11:0] neuron_rd_addr;
   logic [15:0] weight_rd_addr;
   logic        reset_mult_acc_1;
   logic        write_neuron_1;
   logic [11:0] out_neuron_addr_1;
   logic        done_1;
   logic        layer_done;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected beat: {neuron_rd, weight_rd, out_addr, reset, write, done}
   logic [42:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mlp_layer_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .num_inputs        (num_inputs),
      .num_outputs       (num_outputs),
      .in_base_addr      (in_base_addr),
      .out_base_addr     (out_base_addr),
      .weight_base_addr  (weight_base_addr),
      .run               (run),
      .busy              (busy),
      .beat_valid_1      (beat_valid_1),
      .neuron_rd_addr    (neuron_rd_addr),
      .weight_rd_addr    (weight_rd_addr),
      .reset_mult_acc_1  (reset_mult_acc_1),
      .write_neuron_1    (write_neuron_1),
      .out_neuron_addr_1 (out_neuron_addr_1),
      .done_1            (done_1),
      .layer_done        (layer_done),
      .state_dbg         (state_dbg)
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, run, busy, beat_valid_1, neuron_rd_addr, weight_rd_addr,
              reset_mult_acc_1, write_neuron_1, out_neuron_addr_1, done_1,
              layer_done, state_dbg};
   endfunction

   // ---------------- reference model ----------------
   task automatic build_model(input int nin, input int nout, input logic [11:0] ib,
                              input logic [11:0] ob, input logic [15:0] wb);
      logic [11:0] n_a;
      logic [15:0] w_a;
      logic [11:0] o_a;
      exp_q.delete();
      for (int jj = 0; jj < nout; jj++) begin
         for (int ii = 0; ii < nin; ii++) begin
            n_a = 12'(int'(ib) + ii);
            w_a = 16'(int'(wb) + jj * nin + ii);
            o_a = 12'(int'(ob) + jj);
            exp_q.push_back({n_a, w_a, o_a, (ii == 0), (ii == nin - 1),
                             (jj == nout - 1) && (ii == nin - 1)});
         end
      end
   endtask

   // ---------------- driver + per-cycle comparison ----------------
   // Cycle k counts negedges after the edge that samples start: beat b is
   // seen at k=2+b, layer_done at k=2+B+PIPE_LAT (k=2 for an empty layer).
   task automatic run_layer(input int nin, input int nout, input logic [11:0] ib,
                            input logic [11:0] ob, input logic [15:0] wb,
                            input int abort_at, input int repulse_at);
      int          b;
      int          exp_done;
      logic        exp_bv;
      logic [42:0] obs;
      build_model(nin, nout, ib, ob, wb);
      b        = nin * nout;
      exp_done = (b == 0) ? 2 : 2 + b + PIPE_LAT;
      @(negedge clk);
      num_inputs       = 12'(nin);
      num_outputs      = 12'(nout);
      in_base_addr     = ib;
      out_base_addr    = ob;
      weight_base_addr = wb;
      start            = 1'b1;
      for (int k = 1; k <= exp_done + 1; k++) begin
         @(negedge clk);
         start = 1'b0;
         exp_bv = (k >= 2) && (k < 2 + b);
         check_eq($sformatf("beat_valid k=%0d", k), beat_valid_1, exp_bv);
         obs = {neuron_rd_addr, weight_rd_addr, out_neuron_addr_1,
                reset_mult_acc_1, write_neuron_1, done_1};
         if (exp_bv) begin
            if (exp_q.size() > 0) check_eq($sformatf("beat k=%0d", k), obs, exp_q.pop_front());
            else check_eq("beat_underflow", 1, 0);
         end else begin
            check_eq($sformatf("flags k=%0d", k), obs[2:0], 3'b000);
         end
         check_eq($sformatf("layer_done k=%0d", k), layer_done, (k == exp_done));
         check_eq($sformatf("run k=%0d", k), run, (b > 0) && (k >= 2) && (k <= exp_done));
         check_eq($sformatf("busy k=%0d", k), busy, (k <= exp_done));
         if (k == exp_done + 1) check_eq("idle_after_done", state_dbg, S_IDLE);
         if (k == repulse_at) begin
            num_inputs = 12'd7;
            start      = 1'b1;
         end
         if (k == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            check_eq("abort_outputs", all_outs(), 64'd0);
            reset = 1'b0;
            exp_q.delete();
            return;
         end
      end
      check_eq("beats_left", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset            = 1'b1;
      start            = 1'b0;
      num_inputs       = '0;
      num_outputs      = '0;
      in_base_addr     = '0;
      out_base_addr    = '0;
      weight_base_addr = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", all_outs(), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("idle_no_start", all_outs(), 64'd0);

      run_layer(3, 2, 12'h010, 12'h100, 16'h0200, 0, 0);
      run_layer(1, 1, 12'h055, 12'h0AA, 16'h1234, 0, 0);
      run_layer(0, 5, 12'h010, 12'h100, 16'h0200, 0, 0);
      run_layer(3, 0, 12'h010, 12'h100, 16'h0200, 0, 0);
      run_layer(3, 2, 12'h010, 12'h100, 16'h0200, 6, 0);
      run_layer(3, 2, 12'h010, 12'h100, 16'h0200, 0, 0);
      run_layer(3, 2, 12'h010, 12'h100, 16'h0200, 0, 4);
      run_layer(4, 1, 12'hFFE, 12'hFFF, 16'hFFFE, 0, 0);

      for (int t = 0; t < 10; t++) begin
         run_layer(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   12'($urandom), 12'($urandom), 16'($urandom), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
